// File: rtl/usb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// usb_rst_sequencer
//
// Avalon-MM slave that drives the active-low reset of the external USB host
// chip with a timed sequence: a programmable low pulse followed by a
// programmable recovery wait. The sequence runs once automatically after
// system reset and can be restarted from software through CTRL.START.
//
// Ports
//   clk         in   1   system clock
//   reset_n     in   1   asynchronous active-low reset
//   address     in   2   register select (0 CTRL, 1 PULSE, 2 RECOV, 3 STATUS)
//   chipselect  in   1   slave select
//   write_n     in   1   active-low write strobe
//   writedata   in   32  write data
//   readdata    out  32  read data, combinational from address
//   out_port    out  1   USB chip reset, active-low (0 = chip held in reset)
//   irq         out  1   completion interrupt
//
// Build option
//   USB_RST_IRQ_EN  when defined, adds STATUS.irq_en / STATUS.irq_pend and a
//                   registered irq output; when undefined irq is tied low and
//                   STATUS bits 4:3 read as zero.
//
// States
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | sequence finished or aborted; out_port = ~force_q
//   ST_ASSERT  | chip held in reset, counting the low pulse
//   ST_RECOVER | chip released, counting the recovery wait
// -----------------------------------------------------------------------------
module usb_rst_sequencer #(
    parameter int CNT_W       = 24,
    parameter int DEF_PULSE   = 50000,
    parameter int DEF_RECOVER = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] pulse_len, recover_len;
    logic [CNT_W-1:0] pulse_load, recover_load;
    logic             cnt_tc;
    logic             force_q, force_nxt;
    logic             done, done_nxt;
    logic             out_q, out_nxt;
    logic             irq_en, irq_pend;

    logic wr, ctrl_wr, pulse_wr, recov_wr, status_wr;
    logic start_req, abort_req, clr_req;
    logic start_ok, complete;

    // Every writedata bit is consumed somewhere or deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr & (address == 2'd0);
    assign pulse_wr  = wr & (address == 2'd1);
    assign recov_wr  = wr & (address == 2'd2);
    assign status_wr = wr & (address == 2'd3);

    assign start_req = ctrl_wr & writedata[0];
    assign abort_req = ctrl_wr & writedata[2];
    assign clr_req   = status_wr & writedata[2];
    assign force_nxt = ctrl_wr ? writedata[1] : force_q;

    // Zero-length phases are stretched to one cycle so the counter never wraps.
    assign pulse_load   = (pulse_len == '0)   ? CNT_W'(1) : pulse_len;
    assign recover_load = (recover_len == '0) ? CNT_W'(1) : recover_len;

    // Terminal count; <= also covers a stray zero so the decrement can't wrap.
    assign cnt_tc = (cnt <= CNT_W'(1));

    // out_port is registered from the current state, which delays it one
    // edge behind the state: the low pulse spans exactly the load value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done;
        out_nxt   = ~force_nxt;
        start_ok  = 1'b0;
        complete  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = pulse_load;
                end
            end
            ST_ASSERT: begin
                out_nxt = 1'b0;
                if (cnt_tc) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = recover_load;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                out_nxt = 1'b1;
                if (cnt_tc) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    complete  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // ABORT beats everything, including a START in the same write.
        if (abort_req) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            out_nxt   = ~force_nxt;
            start_ok  = 1'b0;
            complete  = 1'b0;
        end

        // A completion in the same cycle as a software clear must win.
        if (start_ok || clr_req) done_nxt = 1'b0;
        if (complete)            done_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_ASSERT;
            cnt         <= CNT_W'(DEF_PULSE);
            pulse_len   <= CNT_W'(DEF_PULSE);
            recover_len <= CNT_W'(DEF_RECOVER);
            force_q     <= 1'b0;
            done        <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            force_q <= force_nxt;
            done    <= done_nxt;
            out_q   <= out_nxt;
            if (pulse_wr) pulse_len   <= writedata[CNT_W-1:0];
            if (recov_wr) recover_len <= writedata[CNT_W-1:0];
        end
    end

    assign out_port = out_q;

`ifdef USB_RST_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (status_wr) irq_en <= writedata[4];
            if (complete) begin
                irq_pend <= 1'b1;
            end else if (clr_req) begin
                irq_pend <= 1'b0;
            end
            irq_q <= irq_en & irq_pend;
        end
    end

    assign irq = irq_q;
`else
    assign irq_en   = 1'b0;
    assign irq_pend = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {30'b0, force_q, 1'b0};
            2'd1:    readdata[CNT_W-1:0] = pulse_len;
            2'd2:    readdata[CNT_W-1:0] = recover_len;
            default: readdata = {27'b0, irq_en, irq_pend, done, state};
        endcase
    end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed testbench for usb_rst_sequencer. Power-on lengths are shortened
// through the parameters so the power-on sequence completes quickly.
module tb_usb_rst_sequencer;

    localparam int P0 = 40;
    localparam int R0 = 70;
`ifdef USB_RST_IRQ_EN
    localparam logic [31:0] PEND = 32'h8;
`else
    localparam logic [31:0] PEND = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usb_rst_sequencer #(
        .CNT_W      (24),
        .DEF_PULSE  (P0),
        .DEF_RECOVER(R0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write accepted at the next edge; returns 1 ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;

        // Reset values
        tick(3);
        chk("rst_out", {31'b0, out_port}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk_rd("rst_status", 2'd3, 32'h1);
        chk_rd("rst_pulse", 2'd1, P0);
        chk_rd("rst_recov", 2'd2, R0);
        chk_rd("rst_ctrl", 2'd0, 32'h0);

        // Power-on sequence: low for P0 edges, done at edge P0+R0
        reset_n = 1'b1;
        tick(P0);
        chk("po_low_end", {31'b0, out_port}, 32'h0);
        tick(1);
        chk("po_high", {31'b0, out_port}, 32'h1);
        chk_rd("po_recover", 2'd3, 32'h2);
        tick(R0 - 2);
        chk_rd("po_not_done", 2'd3, 32'h2);
        tick(1);
        chk_rd("po_done", 2'd3, 32'h4 | PEND);
        wr(2'd3, 32'h4);
        chk_rd("po_clr", 2'd3, 32'h0);

        // PULSE=3, RECOV=2; upper PULSE bits are dropped
        wr(2'd1, 32'hFF00_0003);
        wr(2'd2, 32'h2);
        chk_rd("pulse_rd", 2'd1, 32'h3);
        wr(2'd0, 32'h1);
        chk("t2_T_out", {31'b0, out_port}, 32'h1);
        chk_rd("t2_T_status", 2'd3, 32'h1);
        tick(1);
        chk("t2_T1_out", {31'b0, out_port}, 32'h0);
        tick(2);
        chk("t2_T3_out", {31'b0, out_port}, 32'h0);
        tick(1);
        chk("t2_T4_out", {31'b0, out_port}, 32'h1);
        chk_rd("t2_T4_status", 2'd3, 32'h2);
        tick(1);
        chk_rd("t2_T5_status", 2'd3, 32'h4 | PEND);

        // Zero lengths act as 1; START clears done but leaves irq_pend
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h1);
        chk_rd("t3_T_status", 2'd3, 32'h1 | PEND);
        tick(1);
        chk("t3_T1_out", {31'b0, out_port}, 32'h0);
        chk_rd("t3_T1_status", 2'd3, 32'h2 | PEND);
        tick(1);
        chk("t3_T2_out", {31'b0, out_port}, 32'h1);
        chk_rd("t3_T2_status", 2'd3, 32'h4 | PEND);

        // START while busy is ignored
        wr(2'd3, 32'h4);
        wr(2'd1, 32'd100);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'h1);
        tick(9);
        wr(2'd0, 32'h1);
        chk("t4_T10_out", {31'b0, out_port}, 32'h0);
        tick(89);
        chk_rd("t4_T99_status", 2'd3, 32'h1);
        tick(1);
        chk("t4_T100_out", {31'b0, out_port}, 32'h0);
        chk_rd("t4_T100_status", 2'd3, 32'h2);
        tick(1);
        chk("t4_T101_out", {31'b0, out_port}, 32'h1);
        tick(4);
        chk_rd("t4_T105_status", 2'd3, 32'h4 | PEND);

        // ABORT+START in IDLE: nothing starts, done unchanged
        wr(2'd0, 32'h5);
        tick(2);
        chk_rd("t4_abst_status", 2'd3, 32'h4 | PEND);
        chk("t4_abst_out", {31'b0, out_port}, 32'h1);

        // ABORT mid-pulse
        wr(2'd3, 32'h4);
        wr(2'd0, 32'h1);
        tick(19);
        wr(2'd0, 32'h4);
        chk("t4_abort_out", {31'b0, out_port}, 32'h1);
        chk_rd("t4_abort_status", 2'd3, 32'h0);
        tick(3);
        chk("t4_abort_out3", {31'b0, out_port}, 32'h1);
        chk_rd("t4_abort_status3", 2'd3, 32'h0);

        // PULSE write while busy applies only to the next load
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        tick(1);
        wr(2'd1, 32'd2);
        tick(3);
        chk("t4b_T5_out", {31'b0, out_port}, 32'h0);
        tick(1);
        chk("t4b_T6_out", {31'b0, out_port}, 32'h1);
        tick(2);
        chk_rd("t4b_T8_status", 2'd3, 32'h4 | PEND);
        chk_rd("t4b_pulse", 2'd1, 32'd2);

        // FORCE in IDLE, overridden by the sequence while busy
        wr(2'd3, 32'h4);
        wr(2'd0, 32'h2);
        chk("t5_force_out", {31'b0, out_port}, 32'h0);
        chk_rd("t5_ctrl", 2'd0, 32'h2);
        tick(3);
        chk("t5_force_hold", {31'b0, out_port}, 32'h0);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h3);
        tick(2);
        chk("t5_T2_out", {31'b0, out_port}, 32'h0);
        tick(1);
        chk("t5_T3_out", {31'b0, out_port}, 32'h1);
        chk_rd("t5_T3_status", 2'd3, 32'h2);
        tick(1);
        chk("t5_T4_out", {31'b0, out_port}, 32'h1);
        chk_rd("t5_T4_status", 2'd3, 32'h4 | PEND);
        tick(1);
        chk("t5_T5_out", {31'b0, out_port}, 32'h0);
        wr(2'd0, 32'h0);
        chk("t5_unforce_out", {31'b0, out_port}, 32'h1);
        chk_rd("t5_ctrl0", 2'd0, 32'h0);

        // Reset mid-RECOVER reruns the power-on sequence
        wr(2'd2, 32'd50);
        wr(2'd0, 32'h1);
        tick(5);
        chk("t5r_recover_out", {31'b0, out_port}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t5r_async_out", {31'b0, out_port}, 32'h0);
        chk_rd("t5r_status", 2'd3, 32'h1);
        chk_rd("t5r_pulse", 2'd1, P0);
        tick(2);
        reset_n = 1'b1;
        tick(P0);
        chk("t5r_po_low", {31'b0, out_port}, 32'h0);
        tick(1);
        chk("t5r_po_high", {31'b0, out_port}, 32'h1);
        tick(R0 - 1);
        chk_rd("t5r_po_done", 2'd3, 32'h4 | PEND);

`ifdef USB_RST_IRQ_EN
        // Interrupt path
        wr(2'd3, 32'h4);
        wr(2'd3, 32'h10);
        chk_rd("t6_en", 2'd3, 32'h10);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h1);
        tick(4);
        chk_rd("t6_done", 2'd3, 32'h1C);
        chk("t6_irq_lag", {31'b0, irq}, 32'h0);
        tick(1);
        chk("t6_irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h14);
        tick(1);
        chk("t6_irq_clr", {31'b0, irq}, 32'h0);
        chk_rd("t6_status", 2'd3, 32'h10);
`else
        // Interrupt compiled out: bits 4:3 ignored, irq stays low
        wr(2'd3, 32'h1C);
        chk_rd("t6_status", 2'd3, 32'h0);
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h1);
        tick(2);
        chk_rd("t6_done", 2'd3, 32'h4);
        tick(1);
        chk("t6_irq", {31'b0, irq}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
